// File: rtl/tpsram_be.sv
// Two-port SRAM model: one write port, one read port, single clock.
// Byte-enable writes, 1- or 2-cycle read latency with a valid strobe,
// selectable read-during-write result and an optional post-reset clear.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | zeroing mem[cnt_q] each cycle; port requests are ignored
// ST_READY | normal read/write operation until the next reset
module tpsram_be #(
  parameter int DEPTH      = 8,
  parameter int WIDTH      = 32,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1,
  localparam int DEPTH_LOG = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NB        = WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [DEPTH_LOG-1:0] wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic [NB-1:0]        wbe,
  input  logic                 re,
  input  logic [DEPTH_LOG-1:0] ra,
  output logic [WIDTH-1:0]     rd,
  output logic                 rvalid,
  output logic                 init_busy
);

  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_chk_width
    $error("tpsram_be: WIDTH (%0d) must be a non-zero multiple of 8", WIDTH);
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_chk_lat
    $error("tpsram_be: RD_LAT (%0d) must be 1 or 2", RD_LAT);
  end

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Addresses are compared one bit wider so a non-power-of-2 DEPTH is exact.
  localparam logic [DEPTH_LOG-1:0] CNT_LAST = DEPTH_LOG'(DEPTH - 1);
  localparam logic [DEPTH_LOG:0]   DEPTH_W  = (DEPTH_LOG + 1)'(DEPTH);

  state_e               state_q, state_d;
  logic [DEPTH_LOG-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             ready;
  logic             wr_en;
  logic             rd_en;
  logic             ra_ok;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd1_q;
  logic             rv1_q;

  function automatic logic [WIDTH-1:0] byte_merge(input logic [WIDTH-1:0] old_w,
                                                  input logic [WIDTH-1:0] new_w,
                                                  input logic [NB-1:0]    be);
    logic [WIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Clear sequencer state; reset restarts the clear from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: walk the array once, then park in READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  assign init_busy = (state_q == ST_CLEAR);
  assign ready     = (state_q == ST_READY);
  assign wr_en     = ready & we & ({1'b0, wa} < DEPTH_W);
  assign rd_en     = ready & re;
  assign ra_ok     = ({1'b0, ra} < DEPTH_W);

  // Array update: clear writes take priority; user writes merge per byte.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      mem[wa] <= byte_merge(mem[wa], wd, wbe);
    end
  end

  // Read word select: out-of-range reads give 0; same-address bypass when enabled.
  always_comb begin
    rd_word = '0;
    if (ra_ok) begin
      rd_word = mem[ra];
      if ((RDW_MODE != 0) && wr_en && (wa == ra)) begin
        rd_word = byte_merge(mem[ra], wd, wbe);
      end
    end
  end

  // First read register: captures only on an accepted read so rd holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q <= '0;
      rv1_q <= 1'b0;
    end else begin
      rv1_q <= rd_en;
      if (rd_en) rd1_q <= rd_word;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [WIDTH-1:0] rd2_q;
    logic             rv2_q;

    // Extra output register stage for the 2-cycle latency option.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd2_q <= '0;
        rv2_q <= 1'b0;
      end else begin
        rv2_q <= rv1_q;
        if (rv1_q) rd2_q <= rd1_q;
      end
    end

    assign rd     = rd2_q;
    assign rvalid = rv2_q;
  end else begin : g_lat1
    assign rd     = rd1_q;
    assign rvalid = rv1_q;
  end

endmodule
